// File: rtl/svc_soc_io_arb.sv
// Two-master arbiter for the SoC I/O register bus: the CPU always wins, and an aux
// valid/ready master is buffered and issued only on idle bus cycles, with a starvation flag.
module svc_soc_io_arb #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_ren,
    input  logic [AW-1:0]     cpu_raddr,
    output logic [DW-1:0]     cpu_rdata,
    input  logic              cpu_wen,
    input  logic [AW-1:0]     cpu_waddr,
    input  logic [DW-1:0]     cpu_wdata,
    input  logic [DW/8-1:0]   cpu_wstrb,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic              aux_write,
    input  logic [AW-1:0]     aux_addr,
    input  logic [DW-1:0]     aux_wdata,
    input  logic [DW/8-1:0]   aux_wstrb,
    output logic              aux_rsp_valid,
    output logic [DW-1:0]     aux_rsp_rdata,
    output logic              aux_starved,
    output logic              io_ren,
    output logic [AW-1:0]     io_raddr,
    input  logic [DW-1:0]     io_rdata,
    output logic              io_wen,
    output logic [AW-1:0]     io_waddr,
    output logic [DW-1:0]     io_wdata,
    output logic [DW/8-1:0]   io_wstrb
);
    localparam int SW = DW / 8;
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT_W = WW'(STARVE_LIMIT);

    logic            pend_r;
    logic            pend_write_r;
    logic [AW-1:0]   pend_addr_r;
    logic [DW-1:0]   pend_wdata_r;
    logic [SW-1:0]   pend_wstrb_r;
    logic            rd_aux_r;
    logic [WW-1:0]   wait_r;
    logic            starved_r;

    logic            cpu_busy_s;
    logic            issue_s;
    logic            accept_s;
    logic            blocked_s;
    logic [WW-1:0]   wait_inc_s;

    assign cpu_busy_s = cpu_ren | cpu_wen;
    assign issue_s    = pend_r & ~cpu_busy_s;
    assign aux_ready  = ~pend_r | issue_s;
    assign accept_s   = aux_valid & aux_ready;
    assign blocked_s  = pend_r & cpu_busy_s;
    assign wait_inc_s = (wait_r == LIMIT_W) ? LIMIT_W : (wait_r + WW'(1'b1));

    assign cpu_rdata     = io_rdata;
    assign aux_rsp_valid = rd_aux_r;
    assign aux_rsp_rdata = io_rdata;
    assign aux_starved   = starved_r;

    // Downstream bus mux: CPU pass-through, else the buffered aux request, else idle.
    always_comb begin
        io_ren   = 1'b0;
        io_raddr = {AW{1'b0}};
        io_wen   = 1'b0;
        io_waddr = {AW{1'b0}};
        io_wdata = {DW{1'b0}};
        io_wstrb = {SW{1'b0}};
        if (cpu_busy_s) begin
            io_ren   = cpu_ren;
            io_raddr = cpu_raddr;
            io_wen   = cpu_wen;
            io_waddr = cpu_waddr;
            io_wdata = cpu_wdata;
            io_wstrb = cpu_wstrb;
        end else if (issue_s) begin
            if (pend_write_r) begin
                io_wen   = 1'b1;
                io_waddr = pend_addr_r;
                io_wdata = pend_wdata_r;
                io_wstrb = pend_wstrb_r;
            end else begin
                io_ren   = 1'b1;
                io_raddr = pend_addr_r;
            end
        end else begin
            io_ren = 1'b0;
        end
    end

    // One-entry aux request buffer; an issue and a fresh accept in one cycle reload it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r       <= 1'b0;
            pend_write_r <= 1'b0;
            pend_addr_r  <= {AW{1'b0}};
            pend_wdata_r <= {DW{1'b0}};
            pend_wstrb_r <= {SW{1'b0}};
        end else if (accept_s) begin
            pend_r       <= 1'b1;
            pend_write_r <= aux_write;
            pend_addr_r  <= aux_addr;
            pend_wdata_r <= aux_wdata;
            pend_wstrb_r <= aux_wstrb;
        end else if (issue_s) begin
            pend_r <= 1'b0;
        end
    end

    // Marks the cycle in which the bank returns data for an aux read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_aux_r <= 1'b0;
        end else begin
            rd_aux_r <= issue_s & ~pend_write_r;
        end
    end

    // Starvation monitor: counts consecutive blocked cycles; the flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_r    <= {WW{1'b0}};
            starved_r <= 1'b0;
        end else begin
            if (blocked_s) begin
                wait_r <= wait_inc_s;
            end else begin
                wait_r <= {WW{1'b0}};
            end
            if (blocked_s && (wait_inc_s == LIMIT_W)) begin
                starved_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_svc_soc_io_arb.sv
// Self-checking bench for svc_soc_io_arb: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the arbiter.
module tb_svc_soc_io_arb;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_ren, cpu_wen, aux_valid, aux_write;
    logic [31:0] cpu_raddr, cpu_waddr, cpu_wdata, aux_addr, aux_wdata;
    logic [3:0]  cpu_wstrb, aux_wstrb;
    logic [31:0] cpu_rdata, aux_rsp_rdata, io_raddr, io_waddr, io_wdata;
    logic [31:0] io_rdata = 32'h0;
    logic        aux_ready, aux_rsp_valid, aux_starved, io_ren, io_wen;
    logic [3:0]  io_wstrb;

    always #5 clk = ~clk;

    svc_soc_io_arb #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .cpu_rdata(cpu_rdata),
        .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_write(aux_write), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_wstrb(aux_wstrb),
        .aux_rsp_valid(aux_rsp_valid), .aux_rsp_rdata(aux_rsp_rdata), .aux_starved(aux_starved),
        .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(io_rdata),
        .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb)
    );

    // Register bank: read-only contents, data one cycle after io_ren.
    logic [31:0] mem [16];
    always @(posedge clk) if (io_ren) io_rdata <= mem[io_raddr[5:2]];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s; } req_t;
    typedef struct { int due; logic [31:0] a; } rsp_t;
    req_t pq[$];
    rsp_t rq[$];
    int   cyc = 0;
    int   blocked = 0;
    logic m_starved = 1'b0;
    logic m_acc = 1'b0;

    // Transaction-level reference: checks this cycle's outputs, then advances one cycle.
    always @(negedge clk) begin : model
        logic busy, e_ready, e_ren, e_wen, e_rv;
        logic [31:0] e_raddr, e_waddr, e_wdata;
        logic [3:0]  e_wstrb;
        if (!rst_n) begin
            pq.delete(); rq.delete();
            blocked = 0; m_starved = 1'b0;
        end
        busy = cpu_ren | cpu_wen;
        e_ready = (pq.size() == 0) || !busy;
        e_ren = 1'b0; e_wen = 1'b0; e_raddr = 32'h0; e_waddr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
        if (busy) begin
            e_ren = cpu_ren; e_raddr = cpu_raddr; e_wen = cpu_wen;
            e_waddr = cpu_waddr; e_wdata = cpu_wdata; e_wstrb = cpu_wstrb;
        end else if (pq.size() > 0) begin
            if (pq[0].w) begin
                e_wen = 1'b1; e_waddr = pq[0].a; e_wdata = pq[0].d; e_wstrb = pq[0].s;
            end else begin
                e_ren = 1'b1; e_raddr = pq[0].a;
            end
        end
        e_rv = (rq.size() > 0) && (rq[0].due == cyc);
        check_val("io_ren", 32'(io_ren), 32'(e_ren));
        check_val("io_raddr", io_raddr, e_raddr);
        check_val("io_wen", 32'(io_wen), 32'(e_wen));
        check_val("io_waddr", io_waddr, e_waddr);
        check_val("io_wdata", io_wdata, e_wdata);
        check_val("io_wstrb", 32'(io_wstrb), 32'(e_wstrb));
        check_val("aux_ready", 32'(aux_ready), 32'(e_ready));
        check_val("aux_rsp_valid", 32'(aux_rsp_valid), 32'(e_rv));
        check_val("aux_starved", 32'(aux_starved), 32'(m_starved));
        check_val("cpu_rdata", cpu_rdata, io_rdata);
        if (e_rv) begin
            check_val("aux_rsp_rdata", aux_rsp_rdata, mem[rq[0].a[5:2]]);
            void'(rq.pop_front());
        end
        m_acc = 1'b0;
        if (rst_n) begin
            m_acc = aux_valid && e_ready;
            if (pq.size() > 0 && busy) begin
                blocked++;
                if (blocked >= LIMIT) m_starved = 1'b1;
            end else begin
                blocked = 0;
            end
            if (pq.size() > 0 && !busy) begin
                if (!pq[0].w) rq.push_back('{due: cyc + 1, a: pq[0].a});
                void'(pq.pop_front());
            end
            if (m_acc) pq.push_back('{w: aux_write, a: aux_addr, d: aux_wdata, s: aux_wstrb});
        end
        cyc++;
    end

    task automatic drive(input logic rst, input logic ren, input logic wen, input logic av,
                         input logic aw, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws);
        @(posedge clk);
        #1;
        rst_n = rst;
        cpu_ren = ren; cpu_wen = wen;
        cpu_raddr = $urandom; cpu_waddr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom);
        aux_valid = av; aux_write = aw; aux_addr = addr; aux_wdata = wd; aux_wstrb = ws;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[1] = 32'hDEADBEEF;
        cpu_ren = 1'b0; cpu_wen = 1'b0; aux_valid = 1'b0; aux_write = 1'b0;
        cpu_raddr = 32'h0; cpu_waddr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
        aux_addr = 32'h0; aux_wdata = 32'h0; aux_wstrb = 4'h0;

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_val("rst_ready", 32'(aux_ready), 32'd1);
        check_val("rst_rsp", 32'(aux_rsp_valid), 32'd0);
        check_val("rst_starved", 32'(aux_starved), 32'd0);
        idle();
        check_val("rst_no_issue", 32'(io_ren), 32'd0);

        // Aux read with idle CPU: issue at N+1, response at N+2.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0);
        idle();
        check_val("rd_issue_ren", 32'(io_ren), 32'd1);
        check_val("rd_issue_addr", io_raddr, 32'h8000_0004);
        idle();
        check_val("rd_rsp_valid", 32'(aux_rsp_valid), 32'd1);
        check_val("rd_rsp_data", aux_rsp_rdata, 32'hDEADBEEF);
        idle();
        check_val("rd_rsp_pulse", 32'(aux_rsp_valid), 32'd0);

        // Collision: pending aux write held off by three CPU writes.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h55, 4'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            check_val("col_waddr", io_waddr, cpu_waddr);
            check_val("col_wdata", io_wdata, cpu_wdata);
            check_val("col_ready", 32'(aux_ready), 32'd0);
        end
        idle();
        check_val("col_aux_wen", 32'(io_wen), 32'd1);
        check_val("col_aux_waddr", io_waddr, 32'h10);
        check_val("col_aux_wdata", io_wdata, 32'h55);
        check_val("col_aux_wstrb", 32'(io_wstrb), 32'h1);

        // Streaming: four back-to-back aux reads.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, i < 4, 1'b0, 32'h20 + 32'(4 * i), 32'h0, 4'h0);
            if (i < 4) check_val("str_ready", 32'(aux_ready), 32'd1);
            if (i >= 1 && i <= 4) begin
                check_val("str_ren", 32'(io_ren), 32'd1);
                check_val("str_raddr", io_raddr, 32'h20 + 32'(4 * (i - 1)));
            end
            if (i >= 2) begin
                a = 32'h20 + 32'(4 * (i - 2));
                check_val("str_rsp_valid", 32'(aux_rsp_valid), 32'd1);
                check_val("str_rsp_data", aux_rsp_rdata, mem[a[5:2]]);
            end
        end

        // CPU read and write together while aux is pending.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_val("rw_ren", 32'(io_ren), 32'd1);
        check_val("rw_wen", 32'(io_wen), 32'd1);
        check_val("rw_raddr", io_raddr, cpu_raddr);
        check_val("rw_waddr", io_waddr, cpu_waddr);
        check_val("rw_ready", 32'(aux_ready), 32'd0);
        idle();
        check_val("rw_aux_raddr", io_raddr, 32'h30);
        idle();

        // Starvation: four blocked cycles set the sticky flag.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
        for (int i = 0; i < LIMIT; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            check_val("stv_not_yet", 32'(aux_starved), 32'd0);
        end
        idle();
        check_val("stv_set", 32'(aux_starved), 32'd1);
        check_val("stv_issue", io_raddr, 32'h34);
        idle();
        check_val("stv_sticky", 32'(aux_starved), 32'd1);

        // Reset mid-stream: drops the pending request and the in-flight response.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h38, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3C, 32'h0, 4'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_val("mrst_rsp", 32'(aux_rsp_valid), 32'd0);
        check_val("mrst_ready", 32'(aux_ready), 32'd1);
        check_val("mrst_wen", 32'(io_wen), 32'd0);
        check_val("mrst_starved", 32'(aux_starved), 32'd0);
        idle();
        check_val("mrst_no_issue", 32'(io_ren), 32'd0);
        idle();
        check_val("mrst_no_rsp", 32'(aux_rsp_valid), 32'd0);

        // Random traffic; the requester holds each request until the model sees it accepted.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (aux_valid && m_acc) aux_valid = 1'b0;
            if (!aux_valid && ($urandom_range(0, 9) < 6)) begin
                aux_valid = 1'b1;
                aux_write = 1'($urandom);
                aux_addr = $urandom;
                aux_wdata = $urandom;
                aux_wstrb = 4'($urandom);
            end
            cpu_ren = ($urandom_range(0, 9) < 4);
            cpu_wen = ($urandom_range(0, 9) < 3);
            cpu_raddr = $urandom; cpu_waddr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom);
        end
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/svc_soc_io_arb.md
# svc_soc_io_arb

Two-master arbiter for the SoC I/O register bus. It sits between the RISC-V SoC I/O port and the I/O register bank, and lets a secondary requester share that bus with the CPU. The secondary requester is a debug/loader/DMA agent using a valid/ready handshake. The CPU port has no backpressure, so the CPU always wins; the auxiliary master gets only the idle bus cycles, and a starvation monitor flags if it waits too long.

## Interface
Parameters:
- `AW`, 32, address width for all address ports.
- `DW`, 32, data width; the strobe width is `DW/8`.
- `STARVE_LIMIT`, 1024, number of consecutive blocked cycles of a pending aux request that sets `aux_starved`. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_ren`  in  1  CPU read strobe.
- `cpu_raddr`  in  AW  CPU read address.
- `cpu_rdata`  out  DW  CPU read data, valid in the cycle after `cpu_ren`.
- `cpu_wen`  in  1  CPU write strobe.
- `cpu_waddr`  in  AW  CPU write address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_wstrb`  in  DW/8  CPU write byte strobes.
- `aux_valid`  in  1  aux request valid.
- `aux_ready`  out  1  aux request accepted when this and `aux_valid` are both high.
- `aux_write`  in  1  request type: 1 = write, 0 = read.
- `aux_addr`  in  AW  aux request address.
- `aux_wdata`  in  DW  aux write data.
- `aux_wstrb`  in  DW/8  aux write byte strobes.
- `aux_rsp_valid`  out  1  one-cycle pulse marking aux read data.
- `aux_rsp_rdata`  out  DW  aux read data, qualified by `aux_rsp_valid`.
- `aux_starved`  out  1  sticky starvation flag.
- `io_ren`, `io_raddr`, `io_rdata` (in), `io_wen`, `io_waddr`, `io_wdata`, `io_wstrb`: downstream I/O bus.
  - Same widths as the CPU port.
  - Read data returns one cycle after `io_ren`.

## Operation
Aux request buffer:
- One-entry buffer `pend_q` holding {write, addr, wdata, wstrb}.
- `cpu_busy = cpu_ren | cpu_wen`.
- `issue = pend_q & ~cpu_busy`.
- `aux_ready = ~pend_q | issue`.
- An accepted request is registered at the clock edge; it never passes combinationally to the I/O bus in the same cycle.
- On `issue` with no new accept, `pend_q` clears. On `issue` together with a new accept, the buffer reloads and `pend_q` stays set.

Downstream mux (combinational):
- When `cpu_busy`: CPU signals pass straight through. CPU read and write may be asserted together.
- Else when `issue`: the aux request drives the bus.
  - Write: `io_wen=1` with aux addr, data and strobes.
  - Read: `io_ren=1` with `io_raddr=aux_addr`.
- Else: all `io_*` outputs are 0.

Read return:
- `cpu_rdata = io_rdata` at all times.
- `rd_aux_q` is set for one cycle after an aux read issues.
- `aux_rsp_valid = rd_aux_q` and `aux_rsp_rdata = io_rdata`.
- Aux writes produce no response.
- Back-to-back aux reads give back-to-back response pulses.

Starvation monitor:
- `wait_q` is `$clog2(STARVE_LIMIT+1)` bits wide.
- It increments in each cycle where `pend_q & cpu_busy`, saturating at `STARVE_LIMIT`.
- It clears to 0 on `issue` or when `~pend_q`.
- `aux_starved` is set when `wait_q == STARVE_LIMIT` and is cleared only by reset.

## Timing
- Reset values:
  - `pend_q=0`, `rd_aux_q=0`, `wait_q=0`.
  - `aux_rsp_valid=0`, `aux_starved=0`, `aux_ready=1`.
  - All `io_*` outputs are 0 unless a CPU strobe is high; the CPU pass-through is combinational.
- Minimum aux latency: accept at edge N, issue in cycle N+1 if the CPU is idle, response pulse in cycle N+2.
- CPU latency: zero added cycles; the CPU path is purely combinational.
- CPU strobe in the same cycle as a pending aux request: the CPU wins, aux holds, and `aux_ready=0` (buffer full, not issuing).
- Reset asserted mid-operation: the pending request is dropped and any in-flight response pulse is suppressed. The requester must re-issue.
- `aux_valid` must hold stable until accepted; the arbiter does not check this.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with a request pending → `aux_rsp_valid=0`, `aux_ready=1`, `io_ren=io_wen=0`; no issue after release.
- **Aux read, CPU idle:** accept addr 0x8000_0004 at edge N → `io_ren=1` with that addr in cycle N+1; bank returns 0xDEADBEEF → `aux_rsp_valid=1`, `aux_rsp_rdata=0xDEADBEEF` in N+2.
- **Collision:**
  - Setup: aux write pending (addr 0x10, data 0x55, strb 0x1) while `cpu_wen=1` for 3 cycles.
  - Required: `io_waddr` follows the CPU for 3 cycles and `aux_ready=0`.
  - Required: aux write issues in the 4th cycle; the CPU write data is never corrupted.
- **Streaming:** `aux_valid` held high for 4 reads, CPU idle → one issue per cycle and 4 consecutive `aux_rsp_valid` pulses with matching data.
- **Starvation:** `STARVE_LIMIT=4`, aux pending, `cpu_ren=1` for 4 cycles → `aux_starved` rises after the 4th blocked cycle and stays 1 after the aux read issues.
- **CPU read and write in the same cycle:** both pass through unchanged and the aux stays blocked.
